// File: rtl/pwm_gen.sv
// pwm_gen: double-buffered PWM comparator for the free-running counter; also drives
// the counter's synchronous reset. Define PWM_WRAP_IRQ_EN to add a sticky wrap interrupt.
module pwm_gen #(
    parameter int BW = 4
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [BW-1:0] count_i,
    input  logic          en_i,
    input  logic [BW-1:0] duty_i,
    input  logic          dutyValid_i,
    output logic          dutyReady_o,
    output logic          nrstSync_o,
    output logic          pwm_o,
`ifdef PWM_WRAP_IRQ_EN
    input  logic          irqClr_i,
    output logic          irq_o,
`endif
    output logic          wrap_o
);

    localparam logic [BW-1:0] CNT_MAX  = {BW{1'b1}};
    localparam logic [BW-1:0] CNT_ZERO = {BW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [BW-1:0] active_r;
    logic [BW-1:0] active_nxt_s;
    logic [BW-1:0] shadow_r;
    logic [BW-1:0] shadow_nxt_s;
    logic          pending_r;
    logic          pending_nxt_s;
    logic [BW-1:0] prev_count_r;
    logic          pwm_r;
    logic          pwm_nxt_s;
    logic          wrap_r;
    logic          nrst_sync_r;

    logic          start_s;
    logic          run_s;
    logic          wrap_s;
    logic          accept_s;
    logic          transfer_s;
    logic [BW-1:0] duty_eff_s;

    // Next-state logic; run_s also drops the same cycle en_i falls so pwm_o is low once IDLE.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        run_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_i) begin
                    state_nxt_s = ST_RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                run_s = en_i;
                if (en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Period boundary and duty handshake decode.
    always_comb begin
        wrap_s     = (state_r == ST_RUN) && (prev_count_r == CNT_MAX) && (count_i == CNT_ZERO);
        accept_s   = dutyValid_i && !pending_r;
        transfer_s = (wrap_s || start_s) && pending_r;
    end

    // Duty buffer update; accept and transfer are mutually exclusive through pending_r.
    always_comb begin
        active_nxt_s  = active_r;
        shadow_nxt_s  = shadow_r;
        pending_nxt_s = pending_r;
        duty_eff_s    = active_r;
        if (transfer_s) begin
            active_nxt_s  = shadow_r;
            duty_eff_s    = shadow_r;
            pending_nxt_s = 1'b0;
        end else if (accept_s) begin
            shadow_nxt_s  = duty_i;
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Compare uses the freshly transferred duty so count 0 of a new period already obeys it.
    always_comb begin
        pwm_nxt_s = 1'b0;
        if (run_s) begin
            pwm_nxt_s = (count_i < duty_eff_s);
        end else begin
            pwm_nxt_s = 1'b0;
        end
    end

    // State register and counter hold control.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_r     <= ST_IDLE;
            nrst_sync_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            nrst_sync_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Duty buffers and count history.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            active_r     <= CNT_ZERO;
            shadow_r     <= CNT_ZERO;
            pending_r    <= 1'b0;
            prev_count_r <= CNT_ZERO;
        end else begin
            active_r     <= active_nxt_s;
            shadow_r     <= shadow_nxt_s;
            pending_r    <= pending_nxt_s;
            prev_count_r <= count_i;
        end
    end

    // Registered PWM and wrap outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pwm_r  <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            pwm_r  <= pwm_nxt_s;
            wrap_r <= wrap_s;
        end
    end

    assign pwm_o       = pwm_r;
    assign wrap_o      = wrap_r;
    assign nrstSync_o  = nrst_sync_r;
    assign dutyReady_o = !pending_r;

`ifdef PWM_WRAP_IRQ_EN
    logic irq_r;

    // Sticky wrap interrupt; a wrap beats a coincident clear.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            irq_r <= 1'b0;
        end else if (wrap_s) begin
            irq_r <= 1'b1;
        end else if (irqClr_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq_o = irq_r;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with a behavioural model of the free-running counter.
module tb_pwm_gen;
    localparam int BW = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic       duty_valid;
    logic [3:0] duty;
    logic       duty_ready;
    logic       nrst_sync;
    logic       pwm;
    logic       wrap;
    logic [3:0] cnt;
`ifdef PWM_WRAP_IRQ_EN
    logic       irq_clr;
    logic       irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    pwm_gen #(.BW(BW)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .count_i     (cnt),
        .en_i        (en),
        .duty_i      (duty),
        .dutyValid_i (duty_valid),
        .dutyReady_o (duty_ready),
        .nrstSync_o  (nrst_sync),
        .pwm_o       (pwm),
`ifdef PWM_WRAP_IRQ_EN
        .irqClr_i    (irq_clr),
        .irq_o       (irq),
`endif
        .wrap_o      (wrap)
    );

    // counter block: held at 0 while nrstSync is low
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)           cnt <= 4'd0;
        else if (!nrst_sync) cnt <= 4'd0;
        else                 cnt <= cnt + 4'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_count(input string tag, input logic [3:0] val);
        int budget = 0;
        @(negedge clk);
        while (cnt != val && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        check_eq({tag, "_reached"}, 32'(budget < 40), 32'd1);
    endtask

    // Samples one period: index i sees pwm for count i; optional duty writes at given counts.
    task automatic measure_period(input int wr1_cnt, input logic [3:0] wr1_val,
                                  input int wr2_cnt, input logic [3:0] wr2_val,
                                  output logic [15:0] pat, output logic [15:0] rdy,
                                  output int wraps, output int budget);
        budget = 0;
        wraps  = 0;
        pat    = 16'h0000;
        rdy    = 16'h0000;
        @(negedge clk);
        duty_valid = 1'b0;
        while (cnt != 4'd1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            pat[i] = pwm;
            rdy[i] = duty_ready;
            wraps += int'(wrap);
            if (int'(cnt) == wr1_cnt) begin
                duty = wr1_val; duty_valid = 1'b1;
            end else if (int'(cnt) == wr2_cnt) begin
                duty = wr2_val; duty_valid = 1'b1;
            end else begin
                duty_valid = 1'b0;
            end
        end
    endtask

    task automatic do_period(input string tag, input int wr1_cnt, input logic [3:0] wr1_val,
                             input int wr2_cnt, input logic [3:0] wr2_val,
                             input logic [15:0] exp_pat, input logic [15:0] exp_rdy,
                             input int exp_wraps);
        logic [15:0] pat;
        logic [15:0] rdy;
        int          wraps;
        int          budget;
        measure_period(wr1_cnt, wr1_val, wr2_cnt, wr2_val, pat, rdy, wraps, budget);
        check_eq({tag, "_sync"}, 32'(budget < 40), 32'd1);
        check_eq({tag, "_pwm"}, 32'(pat), 32'(exp_pat));
        check_eq({tag, "_ready"}, 32'(rdy), 32'(exp_rdy));
        check_eq({tag, "_wraps"}, 32'(wraps), 32'(exp_wraps));
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; duty_valid = 1'b0; duty = 4'd0;
`ifdef PWM_WRAP_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_pwm", 32'(pwm), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        check_eq("rst_nrst_sync", 32'(nrst_sync), 32'd0);
        check_eq("rst_ready", 32'(duty_ready), 32'd1);
        nrst = 1'b1;
        @(negedge clk);

        // duty 5 written while idle, then start
        duty = 4'd5; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check_eq("accept_ready_low", 32'(duty_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check_eq("start_ready", 32'(duty_ready), 32'd1);
        check_eq("start_nrst_sync", 32'(nrst_sync), 32'd1);
        check_eq("start_cnt", 32'(cnt), 32'd0);
        check_eq("start_wrap", 32'(wrap), 32'd0);

        do_period("p1_duty5",    -1, 4'd0,  -1, 4'd0, 16'h001F, 16'hFFFF, 0);
        do_period("p2_keep5",     7, 4'd12, -1, 4'd0, 16'h001F, 16'h007F, 1);
        do_period("p3_duty12",    3, 4'd0,  -1, 4'd0, 16'h0FFF, 16'h0007, 1);
        do_period("p4_duty0",     3, 4'd15, 10, 4'd9, 16'h0000, 16'h0007, 1);
        do_period("p5_duty15",   -1, 4'd0,  -1, 4'd0, 16'h7FFF, 16'hFFFF, 1);
        do_period("p6_wrap_wr",   0, 4'd3,  -1, 4'd0, 16'h7FFF, 16'hFFFF, 1);
        do_period("p7_deferred", -1, 4'd0,  -1, 4'd0, 16'h7FFF, 16'h0000, 1);
        do_period("p8_duty3",     5, 4'd12, -1, 4'd0, 16'h0007, 16'h001F, 1);

        // stop at count 9 of a duty-12 period
        wait_count("stop", 4'd9);
        check_eq("stop_pre_pwm", 32'(pwm), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check_eq("stop_pwm", 32'(pwm), 32'd0);
        check_eq("stop_nrst_sync", 32'(nrst_sync), 32'd0);
        check_eq("stop_cnt", 32'(cnt), 32'd10);
        @(negedge clk);
        check_eq("stop_cnt_held", 32'(cnt), 32'd0);
        check_eq("stop_wrap", 32'(wrap), 32'd0);
        duty = 4'd7; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check_eq("idle_accept_ready", 32'(duty_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check_eq("restart_cnt", 32'(cnt), 32'd0);
        check_eq("restart_wrap", 32'(wrap), 32'd0);
        check_eq("restart_ready", 32'(duty_ready), 32'd1);
        do_period("p9_restart7", -1, 4'd0, -1, 4'd0, 16'h007F, 16'hFFFF, 0);

        // async reset mid-period with a pending duty
        wait_count("rst_mid", 4'd4);
        duty = 4'd10; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check_eq("pre_rst_pwm", 32'(pwm), 32'd1);
        check_eq("pre_rst_ready", 32'(duty_ready), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check_eq("mid_rst_pwm", 32'(pwm), 32'd0);
        check_eq("mid_rst_ready", 32'(duty_ready), 32'd1);
        check_eq("mid_rst_nrst_sync", 32'(nrst_sync), 32'd0);
        check_eq("mid_rst_wrap", 32'(wrap), 32'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(duty_ready), 32'd1);
        check_eq("post_rst_pwm", 32'(pwm), 32'd0);
        en = 1'b1;
        @(negedge clk);
        do_period("p10_after_rst", -1, 4'd0, -1, 4'd0, 16'h0000, 16'hFFFF, 0);

`ifdef PWM_WRAP_IRQ_EN
        check_eq("irq_idle", 32'(irq), 32'd0);
        do_period("p11_irq", -1, 4'd0, -1, 4'd0, 16'h0000, 16'hFFFF, 1);
        check_eq("irq_set", 32'(irq), 32'd1);
        wait_count("irq_clr", 4'd5);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check_eq("irq_cleared", 32'(irq), 32'd0);
        wait_count("irq_coinc", 4'd0);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check_eq("irq_set_wins", 32'(irq), 32'd1);
        check_eq("irq_coinc_wrap", 32'(wrap), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
